// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - write-only I2C target that decodes SSD1306-style control/data byte streams
module i2c_target_rx #(
  parameter logic [6:0] ADDR        = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  // Receiver states; every encoding of the 3-bit field is used.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_CTRL     = 3'd3;
  localparam logic [2:0] ST_CTRL_ACK = 3'd4;
  localparam logic [2:0] ST_DATA     = 3'd5;
  localparam logic [2:0] ST_DATA_ACK = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  // Synchronizer chains (idle bus is high, so they reset to 1).
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, scl_dly_d;
  logic                   sda_dly_q, sda_dly_d;

  // Receiver state.
  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_phase_q, ack_phase_d;
  logic       co_q, co_d;
  logic       dc_q, dc_d;

  // Registered outputs.
  logic       sda_oe_q, sda_oe_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dc_q, byte_dc_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       busy_q, busy_d;

  // Line events derived from the synchronized levels.
  logic       s_scl, s_sda;
  logic       scl_rise, scl_fall;
  logic       start_cond, stop_cond;
  logic [7:0] new_byte;
  logic       last_bit;

  // Shift the raw pins into the synchronizers and keep one-cycle delayed copies.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_dly_d  = scl_sync_q[SYNC_STAGES-1];
    sda_dly_d  = sda_sync_q[SYNC_STAGES-1];
  end

  assign s_scl      = scl_sync_q[SYNC_STAGES-1];
  assign s_sda      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = s_scl & ~scl_dly_q;
  assign scl_fall   = ~s_scl & scl_dly_q;
  // SDA may only move while SCL is high for a bus condition; SCL must be high
  // in both the current and the delayed sample so data setup never qualifies.
  assign start_cond = s_scl & scl_dly_q & sda_dly_q & ~s_sda;
  assign stop_cond  = s_scl & scl_dly_q & ~sda_dly_q & s_sda;
  assign new_byte   = {shift_q[6:0], s_sda};
  assign last_bit   = (bit_cnt_q == 3'd7);

  // Transaction decoder: bus conditions first, then per-state bit/ACK handling.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ack_phase_d  = ack_phase_q;
    co_d         = co_q;
    dc_d         = dc_q;
    sda_oe_d     = sda_oe_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    busy_d       = busy_q;

    if (start_cond) begin
      // START or repeated START: any partial byte is dropped.
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'h00;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_cond) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      ack_phase_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
      stop_det_d  = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_CTRL, ST_DATA: begin
          if (scl_rise) begin
            shift_d   = new_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              case (state_q)
                ST_ADDR: begin
                  if ((new_byte[7:1] == ADDR) && !new_byte[0]) begin
                    state_d = ST_ADDR_ACK;
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_CTRL: begin
                  // Control byte: Co selects whether another control byte
                  // follows each data byte; D/C# tags the data bytes.
                  co_d    = new_byte[7];
                  dc_d    = new_byte[6];
                  state_d = ST_CTRL_ACK;
                end
                default: begin
                  byte_data_d  = new_byte;
                  byte_dc_d    = dc_q;
                  byte_valid_d = 1'b1;
                  state_d      = ST_DATA_ACK;
                end
              endcase
            end
          end
        end

        ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
          // First falling edge after bit 8 starts the ACK slot, the next one
          // (end of the ninth clock) ends it.
          if (scl_fall) begin
            if (!ack_phase_q) begin
              sda_oe_d    = 1'b1;
              ack_phase_d = 1'b1;
            end else begin
              sda_oe_d    = 1'b0;
              ack_phase_d = 1'b0;
              bit_cnt_d   = 3'd0;
              case (state_q)
                ST_ADDR_ACK: state_d = ST_CTRL;
                ST_CTRL_ACK: state_d = ST_DATA;
                default:     state_d = co_q ? ST_CTRL : ST_DATA;
              endcase
            end
          end
        end

        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
        end
      endcase
    end
  end

  // Synchronizer and delayed-copy flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_dly_d;
      sda_dly_q  <= sda_dly_d;
    end
  end

  // Decoder state and output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      ack_phase_q  <= 1'b0;
      co_q         <= 1'b0;
      dc_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_dc_q    <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      ack_phase_q  <= ack_phase_d;
      co_q         <= co_d;
      dc_q         <= dc_d;
      sda_oe_q     <= sda_oe_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      busy_q       <= busy_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - randomized I2C write stimulus checked against an SSD1306 byte-stream model
`timescale 1ns/1ps
module tb_i2c_target_rx;

  localparam int         Q     = 60;      // quarter SCL period in ns (SCL = clk/24)
  localparam logic [7:0] WADDR = 8'h78;   // 0x3C, write

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_oe, byte_valid, byte_dc, start_det, stop_det, busy;
  logic [7:0] byte_data;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx #(.ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_drv),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_dc   (byte_dc),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor of DUT pulses.
  logic [8:0] got_q[$];
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         pulse_err = 0;
  logic       bv_prev   = 1'b0;

  always @(negedge clk) begin
    if (byte_valid) got_q.push_back({byte_dc, byte_data});
    if (byte_valid && bv_prev) pulse_err++;
    bv_prev = byte_valid;
    if (start_det) start_cnt++;
    if (stop_det) stop_cnt++;
  end

  // Reference model: the bytes of one addressed segment -> ACKs and payload.
  logic [7:0] tx_q[$];
  logic       exp_ack[$];
  logic [8:0] exp_out_q[$];

  task automatic model_txn();
    logic match, in_ctrl, co, dc;
    exp_ack.delete();
    match   = (tx_q[0] == WADDR);
    in_ctrl = 1'b1;
    co      = 1'b0;
    dc      = 1'b0;
    exp_ack.push_back(match);
    for (int i = 1; i < tx_q.size(); i++) begin
      exp_ack.push_back(match);
      if (match) begin
        if (in_ctrl) begin
          co      = tx_q[i][7];
          dc      = tx_q[i][6];
          in_ctrl = 1'b0;
        end else begin
          exp_out_q.push_back({dc, tx_q[i]});
          in_ctrl = co;
        end
      end
    end
  endtask

  task automatic bus_start();
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0; #Q;
    scl_drv = 1'b1; #Q;
    sda_drv = 1'b1; #Q;
  endtask

  task automatic send_bit(input logic b, input logic exp_oe, input string tag);
    sda_drv = b; #Q;
    scl_drv = 1'b1; #Q;
    check(tag, sda_oe, exp_oe);
    #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack, input logic is_addr);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0, "oe_during_data");
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    check("ack_oe", sda_oe, ack);
    check("ack_line", sda_line, !ack);
    if (is_addr) check("busy_after_addr", busy, ack);
    #Q;
    scl_drv = 1'b0; #Q;
  endtask

  task automatic do_bytes();
    model_txn();
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], exp_ack[i], i == 0);
  endtask

  task automatic begin_txn();
    got_q.delete();
    exp_out_q.delete();
    start_cnt = 0;
    stop_cnt  = 0;
    pulse_err = 0;
  endtask

  task automatic end_txn(input int exp_starts);
    bus_stop();
    #200;
    check("byte_count", got_q.size(), exp_out_q.size());
    for (int i = 0; i < exp_out_q.size(); i++)
      check("byte_dc_data", (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_out_q[i]));
    check("start_det_count", start_cnt, exp_starts);
    check("stop_det_count", stop_cnt, 1);
    check("busy_after_stop", busy, 1'b0);
    check("byte_valid_width", pulse_err, 0);
  endtask

  task automatic run_txn();
    begin_txn();
    bus_start();
    do_bytes();
    end_txn(1);
  endtask

  initial begin
    #3;
    #50;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_dc", byte_dc, 1'b0);
    check("rst_start_det", start_det, 1'b0);
    check("rst_stop_det", stop_det, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    #100;

    // Commands with Co=0.
    tx_q = '{WADDR, 8'h00, 8'hAE, 8'hAF};
    run_txn();
    check("cmd_stream_len", got_q.size(), 2);
    // Data stream.
    tx_q = '{WADDR, 8'h40, 8'h55, 8'hAA, 8'hFF};
    run_txn();
    // Co=1: alternating control/payload.
    tx_q = '{WADDR, 8'h80, 8'hAE, 8'hC0, 8'h55};
    run_txn();
    // Wrong address and read of the right address.
    tx_q = '{8'h7A, 8'h00, 8'hAE};
    run_txn();
    tx_q = '{8'h79, 8'h40, 8'h12};
    run_txn();

    // Partial byte cut by a repeated START.
    begin_txn();
    bus_start();
    tx_q = '{WADDR, 8'h00};
    do_bytes();
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2), 1'b0, "oe_partial");
    bus_start();
    tx_q = '{WADDR, 8'h40, 8'h12};
    do_bytes();
    end_txn(2);

    // Reset during the address ACK.
    begin_txn();
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(WADDR[i], 1'b0, "oe_rst_addr");
    sda_drv = 1'b1; #Q;
    scl_drv = 1'b1; #Q;
    check("oe_before_reset", sda_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    check("oe_async_reset", sda_oe, 1'b0);
    check("busy_async_reset", busy, 1'b0);
    #(Q - 1);
    reset_n = 1'b1;
    scl_drv = 1'b0; #Q;
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hAE, 1'b0, 1'b0);
    bus_stop();
    #200;
    check("rst_no_bytes", got_q.size(), 0);
    check("rst_stop_det", stop_cnt, 1);

    // Random transactions.
    for (int t = 0; t < 20; t++) begin
      tx_q.delete();
      if ($urandom_range(0, 2) != 0) tx_q.push_back(WADDR);
      else tx_q.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) tx_q.push_back(8'($urandom_range(0, 255)));
      run_txn();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #20ms;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
